// File: rtl/fir_weight_loader.sv
// fir_weight_loader: shadow/active coefficient store for two FIRs, applied atomically on frame_sync.
module fir_weight_loader #(
    parameter int N_TAPS = 7,
    parameter int W_BITS = 10,
    parameter logic [N_TAPS*W_BITS-1:0] INIT_W = '0,
    parameter int TIMEOUT = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic                       wr_ch,
    input  logic [2:0]                 wr_tap,
    input  logic [W_BITS-1:0]          wr_data,
    output logic                       wr_ack,
    output logic                       wr_err,
    input  logic                       commit,
    input  logic                       frame_sync,
    output logic                       commit_done,
    output logic                       commit_err,
    output logic                       busy,
    output logic                       dirty,
    input  logic                       rd_ch,
    input  logic [2:0]                 rd_tap,
    input  logic                       rd_act,
    output logic [W_BITS-1:0]          rd_data,
    output logic [N_TAPS*W_BITS-1:0]   weights1,
    output logic [N_TAPS*W_BITS-1:0]   weights2
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic {IDLE, ARMED} state_t;
    state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [N_TAPS-1:0][W_BITS-1:0] shadow [2];
    logic [N_TAPS-1:0][W_BITS-1:0] active [2];
    logic [N_TAPS-1:0][W_BITS-1:0] rd_set;
    logic [W_BITS-1:0] rd_next;
    logic wr_ok, wr_bad, apply, tmo;

    assign busy     = state == ARMED;
    assign weights1 = active[0];
    assign weights2 = active[1];

    // A frame_sync only counts once armed, so one arriving with the commit is ignored.
    always_comb begin
        wr_ok   = wr_en && state == IDLE && int'(wr_tap) < N_TAPS;
        wr_bad  = wr_en && !wr_ok;
        apply   = state == ARMED && frame_sync;
        tmo     = state == ARMED && !frame_sync && cnt == CW'(TIMEOUT);
        state_d = (state == IDLE) ? (commit ? ARMED : IDLE) : ((apply || tmo) ? IDLE : ARMED);
        cnt_d   = (state == IDLE) ? '0 : cnt + CW'(1);
        rd_set  = rd_act ? active[rd_ch] : shadow[rd_ch];
        rd_next = (int'(rd_tap) < N_TAPS) ? rd_set[rd_tap] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            shadow[0]   <= INIT_W;
            shadow[1]   <= INIT_W;
            active[0]   <= INIT_W;
            active[1]   <= INIT_W;
            wr_ack      <= 1'b0;
            wr_err      <= 1'b0;
            commit_done <= 1'b0;
            commit_err  <= 1'b0;
            dirty       <= 1'b0;
            rd_data     <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            if (wr_ok) shadow[wr_ch][wr_tap] <= wr_data;
            if (apply) begin
                active[0] <= shadow[0];
                active[1] <= shadow[1];
            end
            wr_ack      <= wr_ok;
            wr_err      <= wr_bad;
            commit_done <= apply;
            commit_err  <= tmo;
            dirty       <= apply ? 1'b0 : (wr_ok ? 1'b1 : dirty);
            rd_data     <= rd_next;
        end
    end
endmodule

// File: tb/tb_fir_weight_loader.sv
// tb_fir_weight_loader: directed stimulus with queued expectations checked by a negedge monitor.
module tb_fir_weight_loader;
    localparam int TIMEOUT = 1023;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic wr_en = 1'b0, wr_ch = 1'b0, commit = 1'b0, frame_sync = 1'b0;
    logic [2:0] wr_tap = '0, rd_tap = '0;
    logic [9:0] wr_data = '0;
    logic rd_ch = 1'b0, rd_act = 1'b0;
    logic wr_ack, wr_err, commit_done, commit_err, busy, dirty;
    logic [9:0] rd_data;
    logic [69:0] weights1, weights2;
    logic rd_req = 1'b0, rd_req_q = 1'b0;
    int cyc = 0;
    int n_chk = 0, n_fail = 0;

    typedef struct {bit err; int cyc;} cev_t;
    bit         wq[$];
    cev_t       cq[$];
    logic [9:0] rq[$];

    fir_weight_loader #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_tap(wr_tap), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_err(wr_err), .commit(commit), .frame_sync(frame_sync),
        .commit_done(commit_done), .commit_err(commit_err), .busy(busy), .dirty(dirty),
        .rd_ch(rd_ch), .rd_tap(rd_tap), .rd_act(rd_act), .rd_data(rd_data),
        .weights1(weights1), .weights2(weights2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_req_q <= rd_req;
    end

    // Monitor: every response the DUT presents is matched against the head of its queue.
    always @(negedge clk) begin
        if (wr_ack || wr_err) begin
            n_chk++;
            if (wq.size() == 0) begin
                n_fail++;
                $display("FAIL wr_resp: unexpected ack=%b err=%b at cycle %0d", wr_ack, wr_err, cyc);
            end else begin
                automatic bit e = wq.pop_front();
                if (wr_ack !== !e || wr_err !== e) begin
                    n_fail++;
                    $display("FAIL wr_resp: got ack=%b err=%b, expected err=%b", wr_ack, wr_err, e);
                end
            end
        end
        if (commit_done || commit_err) begin
            n_chk++;
            if (cq.size() == 0) begin
                n_fail++;
                $display("FAIL commit_resp: unexpected done=%b err=%b at cycle %0d", commit_done, commit_err, cyc);
            end else begin
                automatic cev_t e = cq.pop_front();
                if (commit_done !== !e.err || commit_err !== e.err || (e.cyc >= 0 && cyc != e.cyc)) begin
                    n_fail++;
                    $display("FAIL commit_resp: got done=%b err=%b cycle %0d, expected err=%b cycle %0d",
                             commit_done, commit_err, cyc, e.err, e.cyc);
                end
            end
        end
        if (rd_req_q) begin
            n_chk++;
            if (rq.size() == 0) begin
                n_fail++;
                $display("FAIL rd_data: no expectation queued, got %h", rd_data);
            end else begin
                automatic logic [9:0] e = rq.pop_front();
                if (rd_data !== e) begin
                    n_fail++;
                    $display("FAIL rd_data: got %h expected %h", rd_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic ch, input logic [2:0] tap, input logic [9:0] d, input bit err);
        wr_en = 1'b1; wr_ch = ch; wr_tap = tap; wr_data = d;
        wq.push_back(err);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic ch, input logic [2:0] tap, input logic act, input logic [9:0] exp);
        rd_req = 1'b1; rd_ch = ch; rd_tap = tap; rd_act = act;
        rq.push_back(exp);
        tick();
        rd_req = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic do_sync();
        frame_sync = 1'b1;
        cq.push_back('{1'b0, cyc + 1});
        tick();
        frame_sync = 1'b0;
    endtask

    localparam logic [69:0] W_T3 = 70'h155 << 30;

    initial begin
        repeat (3) tick();
        chk("rst_rd_data", 70'(rd_data), 70'h0);
        rst = 1'b1;
        tick();
        chk("rst_w1", weights1, 70'h0);
        chk("rst_w2", weights2, 70'h0);
        chk("rst_dirty", 70'(dirty), 70'h0);
        chk("rst_busy", 70'(busy), 70'h0);
        for (int a = 0; a < 2; a++)
            for (int c = 0; c < 2; c++)
                for (int t = 0; t < 8; t++)
                    rd(c[0], t[2:0], a[0], 10'h0);

        wr(1'b0, 3'd3, 10'h155, 1'b0);
        chk("wr_dirty", 70'(dirty), 70'h1);
        rd(1'b0, 3'd3, 1'b0, 10'h155);
        rd(1'b0, 3'd3, 1'b1, 10'h000);
        do_commit();
        chk("armed_busy", 70'(busy), 70'h1);
        repeat (4) tick();
        chk("armed_w1_hold", weights1, 70'h0);
        do_sync();
        chk("apply_w1", weights1, W_T3);
        chk("apply_w2", weights2, 70'h0);
        chk("apply_dirty", 70'(dirty), 70'h0);
        chk("apply_busy", 70'(busy), 70'h0);

        wr(1'b0, 3'd7, 10'h3FF, 1'b1);
        rd(1'b0, 3'd7, 1'b0, 10'h000);
        wr(1'b1, 3'd7, 10'h3FF, 1'b1);
        chk("badtap_dirty", 70'(dirty), 70'h0);
        wr(1'b1, 3'd0, 10'h0AA, 1'b0);
        do_commit();
        wr(1'b1, 3'd1, 10'h3FF, 1'b1);
        do_commit();
        do_sync();
        chk("armed_wr_w1", weights1, W_T3);
        chk("armed_wr_w2", weights2, 70'h0AA);
        rd(1'b1, 3'd1, 1'b1, 10'h000);
        rd(1'b1, 3'd1, 1'b0, 10'h000);

        wr(1'b0, 3'd0, 10'h001, 1'b0);
        cq.push_back('{1'b1, cyc + TIMEOUT + 2});
        do_commit();
        repeat (TIMEOUT + 5) tick();
        chk("tmo_w1", weights1, W_T3);
        chk("tmo_w2", weights2, 70'h0AA);
        chk("tmo_dirty", 70'(dirty), 70'h1);
        chk("tmo_busy", 70'(busy), 70'h0);
        rd(1'b0, 3'd0, 1'b1, 10'h000);
        rd(1'b0, 3'd0, 1'b0, 10'h001);

        wr_en = 1'b1; wr_ch = 1'b0; wr_tap = 3'd1; wr_data = 10'h2A5;
        commit = 1'b1; frame_sync = 1'b1;
        rd_req = 1'b1; rd_ch = 1'b0; rd_tap = 3'd1; rd_act = 1'b0;
        wq.push_back(1'b0);
        rq.push_back(10'h000);
        tick();
        wr_en = 1'b0; commit = 1'b0; rd_req = 1'b0;
        chk("same_cyc_busy", 70'(busy), 70'h1);
        chk("same_cyc_w1", weights1, W_T3);
        do_sync();
        chk("late_sync_w1", weights1, W_T3 | (70'h2A5 << 10) | 70'h001);
        chk("late_sync_w2", weights2, 70'h0AA);
        chk("late_sync_dirty", 70'(dirty), 70'h0);

        wr(1'b1, 3'd2, 10'h111, 1'b0);
        do_commit();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst_w1", weights1, 70'h0);
        chk("midrst_w2", weights2, 70'h0);
        chk("midrst_dirty", 70'(dirty), 70'h0);
        chk("midrst_busy", 70'(busy), 70'h0);
        repeat (5) tick();
        rd(1'b1, 3'd2, 1'b0, 10'h000);
        rd(1'b0, 3'd3, 1'b1, 10'h000);

        repeat (5) tick();
        chk("wq_drained", 70'(wq.size()), 70'h0);
        chk("cq_drained", 70'(cq.size()), 70'h0);
        chk("rq_drained", 70'(rq.size()), 70'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
